// File: rtl/neo_pixel_receiver.sv
// NeoPixel single-wire receiver: classifies high pulses into bits, assembles GRB words,
// detects the latch gap and commits clean frames to a readable buffer.
module neo_pixel_receiver #(
    parameter int NUM_PIXELS   = 5,
    parameter int ONE_THRESH   = 27,
    parameter int MIN_HIGH     = 8,
    parameter int MAX_HIGH     = 60,
    parameter int LATCH_CYCLES = 1250
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 neo_in,
    output logic                                 pixel_valid,
    output logic [$clog2(NUM_PIXELS)-1:0]        pixel_num,
    output logic [23:0]                          pixel_grb,
    output logic                                 frame_done,
    output logic                                 frame_ok,
    output logic                                 frame_error,
    output logic [$clog2(NUM_PIXELS*24+1)-1:0]   bits_received,
    output logic                                 busy,
    input  logic [$clog2(NUM_PIXELS)-1:0]        rd_index,
    output logic [23:0]                          rd_grb
);

    localparam int IDX_W = $clog2(NUM_PIXELS);
    localparam int BIT_W = $clog2(NUM_PIXELS*24+1);
    localparam int HC_W  = $clog2(MAX_HIGH+2);
    localparam int LC_W  = $clog2(LATCH_CYCLES+1);

    localparam logic [BIT_W-1:0] FRAME_BITS = BIT_W'(NUM_PIXELS*24);
    localparam logic [IDX_W:0]   WORDS      = (IDX_W+1)'(NUM_PIXELS);
    localparam logic [HC_W-1:0]  HC_MIN     = HC_W'(MIN_HIGH);
    localparam logic [HC_W-1:0]  HC_ONE     = HC_W'(ONE_THRESH);
    localparam logic [HC_W-1:0]  HC_MAX     = HC_W'(MAX_HIGH);
    localparam logic [HC_W-1:0]  HC_SAT     = HC_W'(MAX_HIGH+1);
    localparam logic [LC_W-1:0]  LC_LATCH   = LC_W'(LATCH_CYCLES);

    typedef enum logic [2:0] {SYNC, IDLE, HIGH, LOW, DISCARD} state_t;

    state_t            state;
    logic [1:0]        sync_q;
    logic              s_prev;
    logic [HC_W-1:0]   high_cnt;
    logic [LC_W-1:0]   low_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [4:0]        bit_pos;
    logic [IDX_W:0]    word_idx;
    logic [23:0]       shift_word;
    logic              cur_err;
    logic [23:0]       shadow    [NUM_PIXELS];
    logic [23:0]       committed [NUM_PIXELS];

    logic        s, rise, fall;
    logic        latch_hit, sync_hit, start;
    logic        bit_val;
    logic [23:0] next_word;

    assign s    = sync_q[1];
    assign rise = s & ~s_prev;
    assign fall = ~s & s_prev;

    assign latch_hit = (state == LOW || state == DISCARD) && (low_cnt == LC_LATCH);
    assign sync_hit  = (state == SYNC) && (low_cnt == LC_LATCH);
    // A rising edge coinciding with the latch begins the next frame rather than being lost.
    assign start     = rise && (state == IDLE || latch_hit || sync_hit);

    assign bit_val   = (high_cnt >= HC_ONE);
    assign next_word = {bit_val, shift_word[23:1]};
    assign bits_received = bit_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            s_prev <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            sync_q <= {sync_q[0], neo_in};
            s_prev <= sync_q[1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= SYNC;
            high_cnt    <= '0;
            low_cnt     <= '0;
            bit_cnt     <= '0;
            bit_pos     <= '0;
            word_idx    <= '0;
            shift_word  <= '0;
            cur_err     <= 1'b0;
            pixel_valid <= 1'b0;
            pixel_num   <= '0;
            pixel_grb   <= '0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
            // NOTE: the buffers are reset explicitly because a reset must leave rd_grb reading zero.
            for (int i = 0; i < NUM_PIXELS; i++) shadow[i] <= '0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;

            if (latch_hit) begin
                frame_done  <= 1'b1;
                frame_ok    <= (state == LOW) && (bit_cnt == FRAME_BITS) && !cur_err;
                frame_error <= cur_err || (state == DISCARD) || (bit_pos != 5'd0);
                busy        <= 1'b0;
                state       <= IDLE;
            end

            if (start) begin
                state    <= HIGH;
                high_cnt <= HC_W'(1);
                busy     <= 1'b1;
                bit_cnt  <= '0;
                bit_pos  <= '0;
                word_idx <= '0;
                cur_err  <= 1'b0;
            end else begin
                case (state)
                    SYNC: begin
                        if (sync_hit)  state   <= IDLE;
                        else if (s)    low_cnt <= '0;
                        else           low_cnt <= low_cnt + LC_W'(1);
                    end
                    IDLE: ;
                    HIGH: begin
                        if (high_cnt > HC_MAX || (fall && high_cnt < HC_MIN)) begin
                            state       <= DISCARD;
                            low_cnt     <= s ? '0 : LC_W'(1);
                            cur_err     <= 1'b1;
                            frame_error <= 1'b1;
                        end else if (fall) begin
                            state   <= LOW;
                            low_cnt <= LC_W'(1);
                            if (bit_cnt != FRAME_BITS) bit_cnt <= bit_cnt + BIT_W'(1);
                            if (word_idx == WORDS) begin
                                cur_err     <= 1'b1;
                                frame_error <= 1'b1;
                            end else begin
                                shift_word <= next_word;
                                if (bit_pos == 5'd23) begin
                                    pixel_valid                  <= 1'b1;
                                    pixel_grb                    <= next_word;
                                    pixel_num                    <= word_idx[IDX_W-1:0];
                                    shadow[word_idx[IDX_W-1:0]]  <= next_word;
                                    bit_pos                      <= '0;
                                    word_idx                     <= word_idx + (IDX_W+1)'(1);
                                end else begin
                                    bit_pos <= bit_pos + 5'd1;
                                end
                            end
                        end else if (high_cnt != HC_SAT) begin
                            high_cnt <= high_cnt + HC_W'(1);
                        end
                    end
                    LOW: begin
                        if (!latch_hit) begin
                            if (rise) begin
                                state    <= HIGH;
                                high_cnt <= HC_W'(1);
                            end else begin
                                low_cnt <= low_cnt + LC_W'(1);
                            end
                        end
                    end
                    DISCARD: begin
                        if (!latch_hit) begin
                            if (s) low_cnt <= '0;
                            else   low_cnt <= low_cnt + LC_W'(1);
                        end
                    end
                    default: state <= SYNC;
                endcase
            end
        end
    end

    // Commit lands one cycle after frame_done, while the shadow still holds the finished frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PIXELS; i++) committed[i] <= '0;
        end else if (frame_done && frame_ok) begin
            for (int i = 0; i < NUM_PIXELS; i++) committed[i] <= shadow[i];
        end
    end

    always_comb begin
        // NOTE: default first so no path through this block infers a latch.
        rd_grb = '0;
        if ({1'b0, rd_index} < WORDS) rd_grb = committed[rd_index];
    end

endmodule

// File: tb/tb_neo_pixel_receiver.sv
// Self-checking bench for neo_pixel_receiver: pulse-level stimulus against a
// bit-list reference model of frame decoding and buffer commit.
module tb_neo_pixel_receiver;

    localparam int NPIX       = 5;
    localparam int ONE_THRESH = 27;
    localparam int MIN_HIGH   = 8;
    localparam int MAX_HIGH   = 60;
    localparam int FBITS      = NPIX * 24;

    logic        clock = 1'b0;
    logic        reset;
    logic        neo_in;
    logic        pixel_valid;
    logic [2:0]  pixel_num;
    logic [23:0] pixel_grb;
    logic        frame_done;
    logic        frame_ok;
    logic        frame_error;
    logic [6:0]  bits_received;
    logic        busy;
    logic [2:0]  rd_index;
    logic [23:0] rd_grb;

    neo_pixel_receiver dut (
        .clock         (clock),
        .reset         (reset),
        .neo_in        (neo_in),
        .pixel_valid   (pixel_valid),
        .pixel_num     (pixel_num),
        .pixel_grb     (pixel_grb),
        .frame_done    (frame_done),
        .frame_ok      (frame_ok),
        .frame_error   (frame_error),
        .bits_received (bits_received),
        .busy          (busy),
        .rd_index      (rd_index),
        .rd_grb        (rd_grb)
    );

    always #10 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Event monitor sampled on the falling edge.
    int          pv_cnt = 0;
    int          fd_cnt = 0;
    int          ok_cnt = 0;
    bit          last_ok = 1'b0;
    logic [23:0] pv_words [8];

    always @(negedge clock) begin
        if (!reset) begin
            if (pixel_valid) begin
                pv_cnt++;
                pv_words[pixel_num] = pixel_grb;
            end
            if (frame_done) begin
                fd_cnt++;
                last_ok = frame_ok;
                if (frame_ok) ok_cnt++;
            end
        end
    end

    // Stimulus description and model results.
    int          hi_q[$];
    int          lo_q[$];
    int          exp_pv, exp_bits;
    bit          exp_ok, exp_err;
    logic [23:0] exp_words   [NPIX];
    logic [23:0] committed_m [NPIX];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_pulse(input int h, input int l);
        neo_in = 1'b1;
        repeat (h) @(negedge clock);
        neo_in = 1'b0;
        repeat (l) @(negedge clock);
    endtask

    task automatic send_low(input int n);
        neo_in = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_range(input int from, input int upto);
        for (int i = from; i < upto; i++) send_pulse(hi_q[i], lo_q[i]);
    endtask

    task automatic build_random(input int nbits);
        hi_q.delete();
        lo_q.delete();
        for (int i = 0; i < nbits; i++) begin
            if ($urandom_range(0, 1) == 1) hi_q.push_back(int'($urandom_range(ONE_THRESH, MAX_HIGH)));
            else                           hi_q.push_back(int'($urandom_range(MIN_HIGH, ONE_THRESH - 1)));
            lo_q.push_back(int'($urandom_range(5, 20)));
        end
    endtask

    // Fixed encoding: 1 = 35 high / 30 low, 0 = 18 high / 40 low; LSB of pixel 0 first.
    task automatic build_pattern(input logic [23:0] w0);
        logic [23:0] w;
        hi_q.delete();
        lo_q.delete();
        for (int n = 0; n < FBITS; n++) begin
            w = (n < 24) ? w0 : 24'h0;
            if (w[n % 24]) begin hi_q.push_back(35); lo_q.push_back(30); end
            else           begin hi_q.push_back(18); lo_q.push_back(40); end
        end
    endtask

    // Reference: walk the pulse list, apply the classification rules, place bits arithmetically.
    task automatic model_frame();
        int n;
        bit disc;
        n = 0; disc = 1'b0; exp_pv = 0; exp_err = 1'b0;
        for (int k = 0; k < NPIX; k++) exp_words[k] = 24'h0;
        foreach (hi_q[i]) begin
            if (!disc) begin
                if (hi_q[i] < MIN_HIGH || hi_q[i] > MAX_HIGH) begin
                    disc = 1'b1;
                    exp_err = 1'b1;
                end else if (n >= FBITS) begin
                    exp_err = 1'b1;
                end else begin
                    if (hi_q[i] >= ONE_THRESH) exp_words[n / 24][n % 24] = 1'b1;
                    n++;
                    if (n % 24 == 0) exp_pv++;
                end
            end
        end
        if (!disc && (n % 24) != 0) exp_err = 1'b1;
        exp_bits = n;
        exp_ok   = !exp_err && (n == FBITS);
        if (exp_ok) for (int k = 0; k < NPIX; k++) committed_m[k] = exp_words[k];
    endtask

    task automatic check_rd(input string tag);
        for (int idx = 0; idx < 8; idx++) begin
            rd_index = 3'(idx);
            #1;
            if (idx < NPIX) check($sformatf("%s.rd%0d", tag, idx), rd_grb, committed_m[idx]);
            else            check($sformatf("%s.rd%0d", tag, idx), rd_grb, 24'h0);
        end
        @(negedge clock);
    endtask

    task automatic check_frame(input string tag, input int pv0, input int fd0,
                               input int extra_fd, input int extra_pv);
        check({tag, ".pv"},   pv_cnt - pv0, exp_pv + extra_pv);
        check({tag, ".fd"},   fd_cnt - fd0, 1 + extra_fd);
        check({tag, ".ok"},   last_ok, exp_ok);
        check({tag, ".err"},  frame_error, exp_err);
        check({tag, ".bits"}, bits_received, exp_bits);
        check({tag, ".busy"}, busy, 1'b0);
        for (int k = 0; k < exp_pv; k++)
            check($sformatf("%s.word%0d", tag, k), pv_words[k], exp_words[k]);
        check_rd(tag);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".pv"},   pixel_valid, 1'b0);
        check({tag, ".fd"},   frame_done, 1'b0);
        check({tag, ".ok"},   frame_ok, 1'b0);
        check({tag, ".err"},  frame_error, 1'b0);
        check({tag, ".bits"}, bits_received, 7'd0);
        check({tag, ".busy"}, busy, 1'b0);
        check({tag, ".grb"},  pixel_grb, 24'h0);
        check({tag, ".num"},  pixel_num, 3'd0);
    endtask

    task automatic run_frame(input string tag, input int gap);
        int pv0, fd0;
        pv0 = pv_cnt; fd0 = fd_cnt;
        model_frame();
        send_range(0, hi_q.size());
        send_low(gap);
        check_frame(tag, pv0, fd0, 0, 0);
    endtask

    int pv0, fd0, ok0;

    initial begin
        reset = 1'b1; neo_in = 1'b0; rd_index = 3'd0;
        for (int k = 0; k < NPIX; k++) committed_m[k] = 24'h0;
        for (int k = 0; k < 8; k++) pv_words[k] = 24'h0;
        repeat (3) @(negedge clock);
        check_cleared("por");
        check_rd("por");
        reset = 1'b0;
        repeat (20) @(negedge clock);

        // Line toggles before the initial latch gap: nothing may decode.
        pv0 = pv_cnt; fd0 = fd_cnt;
        build_random(30);
        send_range(0, 30);
        send_low(1300);
        check("presync.pv", pv_cnt - pv0, 0);
        check("presync.fd", fd_cnt - fd0, 0);

        build_pattern(24'h123456);
        run_frame("basic", 2500);
        check("basic.pix0", pv_words[0], 24'h123456);

        build_random(FBITS);
        run_frame("rand", 1300);

        // Threshold edges and a 1249-cycle low gap inside the frame.
        build_random(FBITS);
        hi_q[0] = ONE_THRESH - 1; hi_q[1] = ONE_THRESH;
        hi_q[2] = MIN_HIGH;       hi_q[3] = MAX_HIGH;
        lo_q[60] = 1249;
        run_frame("bound", 1300);

        build_random(FBITS); hi_q[50] = 5;
        run_frame("glitch", 1300);

        build_random(100);
        run_frame("short", 1300);

        build_random(130);
        run_frame("long", 1300);

        build_random(40); hi_q[10] = MAX_HIGH + 1;
        run_frame("stuck", 1300);

        build_random(FBITS);
        run_frame("recover", 1300);

        // Two frames separated by exactly the latch length.
        pv0 = pv_cnt; fd0 = fd_cnt; ok0 = ok_cnt;
        build_random(FBITS);
        lo_q[FBITS - 1] = 1250;
        model_frame();
        send_range(0, FBITS);
        build_random(FBITS);
        model_frame();
        send_range(0, FBITS);
        send_low(1300);
        check("b2b.okcnt", ok_cnt - ok0, 2);
        check_frame("b2b", pv0, fd0, 1, 5);

        // Reset during pixel 2.
        pv0 = pv_cnt;
        build_random(FBITS);
        send_range(0, 55);
        neo_in = 1'b1;
        repeat (10) @(negedge clock);
        check("midframe.busy", busy, 1'b1);
        check("midframe.bits", bits_received, 7'd55);
        check("midframe.pv",   pv_cnt - pv0, 2);
        reset = 1'b1;
        #1;
        check_cleared("rst");
        for (int k = 0; k < NPIX; k++) committed_m[k] = 24'h0;
        check_rd("rst");
        repeat (4) @(negedge clock);
        neo_in = 1'b0;
        reset = 1'b0;
        send_low(100);
        pv0 = pv_cnt; fd0 = fd_cnt;
        build_random(FBITS);
        send_range(0, FBITS);
        send_low(1300);
        check("postrst.pv", pv_cnt - pv0, 0);
        check("postrst.fd", fd_cnt - fd0, 0);
        check_rd("postrst");

        build_random(FBITS);
        run_frame("resync", 1300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neo_pixel_receiver.md
# neo_pixel_receiver

Decodes a single-wire NeoPixel serial stream (the 50 MHz pulse-width format our strand controller drives) back into per-pixel GRB words. Sits at the far end of the strand data line: as a loop-back checker in the bench and FPGA self-test, and as the front end of the daisy-chain emulator. Classifies each high pulse as a 0/1 bit, assembles 24-bit pixel words, and detects the inter-packet latch gap. Commits a complete, error-free frame to a readable double buffer.

## Interface
- NUM_PIXELS, 5, pixels per frame (frame = NUM_PIXELS*24 bits)
- ONE_THRESH, 27, high-pulse length (cycles) at/above which bit = 1
- MIN_HIGH, 8, shorter high pulse = glitch error
- MAX_HIGH, 60, longer high pulse = stuck-high error
- LATCH_CYCLES, 1250, continuous low cycles (25 us) that end a frame
- clock  in  1  50 MHz system clock
- reset  in  1  reset, asynchronous, active-high
- neo_in  in  1  serial line, asynchronous to clock
- pixel_valid  out  1  one-cycle pulse: pixel_grb/pixel_num valid
- pixel_num  out  3  index of pixel just assembled (width $clog2(NUM_PIXELS))
- pixel_grb  out  24  {G[23:16],R[15:8],B[7:0]}
- frame_done  out  1  one-cycle pulse on latch detect after >=1 bit
- frame_ok  out  1  with frame_done: exactly NUM_PIXELS*24 bits, no error
- frame_error  out  1  sticky; set on any error, cleared on next frame_done
- bits_received  out  7  bit count of current frame (width $clog2(NUM_PIXELS*24+1)), saturating
- busy  out  1  high from first rising edge of a frame until frame_done
- rd_index  in  3  committed-buffer read select
- rd_grb  out  24  committed word for rd_index, combinational; 0 if rd_index >= NUM_PIXELS

## Operation
- neo_in passes a 2-flop synchronizer; edges detected on synchronized value s.
- Counters: high_cnt (saturates MAX_HIGH+1), low_cnt (saturates LATCH_CYCLES), bit_cnt, 24-bit shift word.
- States: SYNC, IDLE, HIGH, LOW, DISCARD.
- SYNC (after reset): count low cycles; high clears count; low_cnt == LATCH_CYCLES -> IDLE. Nothing decoded.
- IDLE: rising edge -> HIGH, high_cnt=1, busy=1, bit_cnt=0.
- HIGH: high_cnt++. Falling edge: high_cnt < MIN_HIGH -> DISCARD, error; else bit = (high_cnt >= ONE_THRESH), store, bit_cnt++, -> LOW, low_cnt=1. high_cnt > MAX_HIGH -> DISCARD, error.
- Bit placement: frame bit n -> bit n%24 of word n/24 (first bit received = B[0] of pixel 0). On 24th bit of a word: pixel_valid pulse with that word and pixel_num = n/24; word written into shadow buffer.
- Bits with n >= NUM_PIXELS*24: counted (saturating), not stored, frame_error set.
- LOW: low_cnt++. Rising edge before LATCH_CYCLES -> HIGH (next bit). low_cnt reaches LATCH_CYCLES -> frame_done; frame_ok=1 iff bit_cnt == NUM_PIXELS*24 and no error; if frame_ok, shadow copied to committed buffer in same cycle; -> IDLE, busy=0.
- DISCARD: ignore pulses; requires LATCH_CYCLES continuous low, then frame_done with frame_ok=0, -> IDLE.
- Partial trailing word (bit_cnt%24 != 0) at latch: discarded, frame_ok=0, frame_error=1.
- frame_error clears on the frame_done cycle, then re-asserts if that frame errored (reflects last frame after done).

## Timing
- Reset values: all outputs 0, committed and shadow buffers 0, state SYNC.
- Edge-to-internal latency: 2 cycles (synchronizer) + 1 edge detect.
- pixel_valid: cycle after the falling edge of the word's 24th bit is detected.
- frame_done: cycle after low_cnt reaches LATCH_CYCLES; rd_grb shows new frame the cycle after frame_done.
- Rising edge in the same cycle latch fires: latch processed first, edge starts next frame's first bit (no bit lost).
- Reset mid-frame: immediate clear, shadow discarded, committed buffer zeroed, back to SYNC.
- rd_index change reflected on rd_grb combinationally.

## Test plan
- Post-reset: line low 1250 cycles, then 120 bits (35H/30L =1, 18H/40L =0) encoding pixel0 G=0x12 R=0x34 B=0x56, others 0, then 2500 low -> 5 pixel_valid pulses, pixel 0 grb=0x123456, frame_done with frame_ok=1, rd_grb[0]=0x123456.
- Pulses before SYNC satisfied (line toggling from reset) -> no pixel_valid, no frame_done.
- 5-cycle high glitch mid-frame -> no further pixel_valid, frame_done frame_ok=0, frame_error=1, committed buffer unchanged.
- 100-bit frame then latch -> 4 pixel_valid, frame_ok=0, bits_received=100; 130 bits -> 5 pixel_valid, frame_ok=0, bits_received=120 saturating.
- Boundary pulses: 26-cycle high -> bit 0, 27 -> bit 1, 61 -> error; 1249 low then rising edge -> same frame continues.
- Assert reset during pixel 2 -> outputs 0 immediately, rd_grb all 0, next frame decoded only after 1250 low cycles.
